// File: rtl/pio_in_debounce_pkg.sv
// Shared definitions for the debounced input PIO: register addresses,
// edge-type encodings and the per-bit edge qualifier.
package pio_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA    = 2'd0,
    ADDR_IRQMASK = 2'd1,
    ADDR_EDGECAP = 2'd2,
    ADDR_RSVD    = 2'd3
  } pio_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Qualifies a change of one debounced bit against the selected edge type.
  function automatic logic edge_detect(input logic cur, input logic prev, input int etype);
    case (etype)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/pio_in_debounce_if.sv
// Avalon-MM slave bus plus interrupt line of the input PIO.
interface pio_in_debounce_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain followed by a hold-time debouncer.
// stable only follows the synchronised input after it has disagreed with
// stable for DEBOUNCE_CYCLES consecutive cycles.
module pio_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic stable
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // Shift the raw asynchronous input through the synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
  end

  // Count consecutive disagreeing cycles; accept the new level on the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_bit == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= sync_bit;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pio_in_debounce.sv
// Debounced input PIO: level register, edge-capture register with
// write-1-to-clear, interrupt mask and registered Avalon read mux.
module pio_in_debounce
  import pio_pkg::*;
#(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = EDGE_ANY
) (
  input  logic               clk,
  input  logic               reset,
  pio_in_debounce_if.slave   bus,
  input  logic [WIDTH-1:0]   in_port
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_next;
  logic             wr_en;

  assign wr_en = bus.chipselect & ~bus.write_n;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .reset (reset),
      .in_bit(in_port[g]),
      .stable(stable[g])
    );
  end

  // Qualify each debounced change against the configured edge type.
  always_comb begin
    edge_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_hit[i] = edge_detect(stable[i], stable_d[i], EDGE_TYPE);
    end
  end

  // Bits written as 1 to EDGECAP this cycle.
  always_comb begin
    clr = '0;
    if (wr_en && bus.address == ADDR_EDGECAP) clr = bus.writedata[WIDTH-1:0];
  end

  // Address mux feeding the read register; unused upper bits stay 0.
  always_comb begin
    rd_next = '0;
    case (pio_addr_e'(bus.address))
      ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_next[WIDTH-1:0] = mask;
      ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
      default:      rd_next = '0;
    endcase
  end

  // Delayed level and edge capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_d <= '0;
      edgecap  <= '0;
    end else begin
      stable_d <= stable;
      edgecap  <= (edgecap & ~clr) | edge_hit;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                     mask <= '0;
    else if (wr_en && bus.address == ADDR_IRQMASK) mask <= bus.writedata[WIDTH-1:0];
  end

  // Read data is refreshed every cycle regardless of chipselect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.readdata <= '0;
    else       bus.readdata <= rd_next;
  end

  assign bus.irq = |(edgecap & mask);

endmodule

// File: tb/tb_pio_in_debounce.sv
// Bench for the debounced input PIO: register-access table, hand-written
// latency / glitch / set-vs-clear / reset sequences, a falling-edge variant
// and a long randomized run against a history-window reference model.
module tb_pio_in_debounce;
  import pio_pkg::*;

  localparam int W = 2;
  localparam int S = 2;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] in_port2 = '0;

  int errors = 0;
  int checks = 0;

  pio_in_debounce_if bus ();
  pio_in_debounce_if bus2 ();

  always #5 clk = ~clk;

  pio_in_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_ANY)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .in_port(in_port)
  );

  pio_in_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(EDGE_FALL)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .in_port(in_port2)
  );

  // Reference model: a level is accepted once the raw input, seen S edges
  // late, has shown the opposite value for D consecutive edges.
  logic [W-1:0] hist [S+D];
  logic [W-1:0] m_stab, m_stabd, m_ecap, m_mask;
  logic [31:0]  m_rd;

  task automatic model_reset();
    for (int k = 0; k < S + D; k++) hist[k] = '0;
    m_stab = '0; m_stabd = '0; m_ecap = '0; m_mask = '0; m_rd = '0;
  endtask

  task automatic model_step(input logic [1:0] a, input logic we, input logic [31:0] wd,
                            input logic [W-1:0] inp);
    logic [W-1:0] n_stab, edges, clr;
    logic [31:0]  rd;
    logic         all_opp;
    for (int k = S + D - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = inp;
    n_stab = m_stab;
    for (int b = 0; b < W; b++) begin
      all_opp = 1'b1;
      for (int j = 0; j < D; j++) if (hist[S+j][b] == m_stab[b]) all_opp = 1'b0;
      if (all_opp) n_stab[b] = ~m_stab[b];
    end
    edges = m_stab ^ m_stabd;
    rd = 32'h0;
    if (a == 2'd0) rd[W-1:0] = m_stab;
    if (a == 2'd1) rd[W-1:0] = m_mask;
    if (a == 2'd2) rd[W-1:0] = m_ecap;
    clr = (we && a == 2'd2) ? wd[W-1:0] : '0;
    m_ecap  = (m_ecap & ~clr) | edges;
    if (we && a == 2'd1) m_mask = wd[W-1:0];
    m_rd    = rd;
    m_stabd = m_stab;
    m_stab  = n_stab;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at the falling edge, let one rising edge pass,
  // return at the next falling edge where outputs are sampled.
  task automatic cyc(input logic [1:0] a, input logic cs, input logic wn, input logic [31:0] wd);
    bus.address = a; bus.chipselect = cs; bus.write_n = wn; bus.writedata = wd;
    model_step(a, cs & ~wn, wd, in_port);
    @(posedge clk);
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(a, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus2.address = 2'd2; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;
    model_reset();

    tbl[0]  = '{2'd0, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[1]  = '{2'd1, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[2]  = '{2'd2, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[3]  = '{2'd3, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[4]  = '{2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 1'b0};
    tbl[5]  = '{2'd1, 1'b0, 32'h0,        32'h3, 1'b0};
    tbl[6]  = '{2'd3, 1'b1, 32'h0000FFFF, 32'h0, 1'b0};
    tbl[7]  = '{2'd3, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[8]  = '{2'd0, 1'b1, 32'h3,        32'h0, 1'b0};
    tbl[9]  = '{2'd0, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[10] = '{2'd1, 1'b1, 32'h0,        32'h3, 1'b0};
    tbl[11] = '{2'd1, 1'b0, 32'h0,        32'h0, 1'b0};

    @(negedge clk);
    chk("reset_readdata", bus.readdata, 32'h0);
    chk("reset_irq", {31'h0, bus.irq}, 32'h0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].addr, 1'b1, ~tbl[i].wr, tbl[i].wdata);
      chk($sformatf("tbl%0d_rd", i), bus.readdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_irq", i), {31'h0, bus.irq}, {31'h0, tbl[i].exp_irq});
    end

    // Press bit0: level visible in stable after S+D edges, read one edge later.
    in_port[0] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      rd(2'd0);
      chk($sformatf("latency_k%0d", k), bus.readdata, (k >= 11) ? 32'h1 : 32'h0);
      chk("latency_irq", {31'h0, bus.irq}, 32'h0);
    end
    rd(2'd2);
    chk("press_edgecap", bus.readdata, 32'h1);
    chk("press_irq_masked", {31'h0, bus.irq}, 32'h0);
    wr(2'd1, 32'h1);
    chk("mask_irq_on", {31'h0, bus.irq}, 32'h1);
    wr(2'd2, 32'h1);
    chk("clear_preread", bus.readdata, 32'h1);
    chk("clear_irq_off", {31'h0, bus.irq}, 32'h0);
    rd(2'd2);
    chk("clear_edgecap", bus.readdata, 32'h0);

    // Glitch one cycle short of the debounce time on bit1.
    in_port[1] = 1'b1;
    repeat (7) rd(2'd0);
    in_port[1] = 1'b0;
    repeat (15) rd(2'd0);
    chk("glitch_data", bus.readdata, 32'h1);
    rd(2'd2);
    chk("glitch_edgecap", bus.readdata, 32'h0);

    // Pulse exactly the debounce time: accepted, then released again.
    in_port[1] = 1'b1;
    repeat (8) rd(2'd0);
    in_port[1] = 1'b0;
    repeat (20) rd(2'd0);
    chk("pulse8_data", bus.readdata, 32'h1);
    rd(2'd2);
    chk("pulse8_edgecap", bus.readdata, 32'h2);
    chk("pulse8_irq_masked", {31'h0, bus.irq}, 32'h0);
    wr(2'd2, 32'h2);

    // Release bit0 and write-1-clear on exactly the edge that sets it.
    in_port[0] = 1'b0;
    repeat (10) rd(2'd0);
    chk("setclr_before", {31'h0, bus.irq}, 32'h0);
    wr(2'd2, 32'h1);
    chk("setclr_irq", {31'h0, bus.irq}, 32'h1);
    rd(2'd2);
    chk("setclr_edgecap", bus.readdata, 32'h1);

    // Reset asserted in the middle of a debounce count.
    in_port[0] = 1'b1;
    repeat (5) rd(2'd2);
    chk("prereset_rd", bus.readdata, 32'h1);
    chk("prereset_irq", {31'h0, bus.irq}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_rd", bus.readdata, 32'h0);
    chk("async_reset_irq", {31'h0, bus.irq}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 1; k <= 12; k++) begin
      if (k <= 4) rd(2'(k - 1));
      else        rd(2'd0);
      chk($sformatf("postreset_k%0d", k), bus.readdata, (k >= 11) ? 32'h1 : 32'h0);
    end
    rd(2'd2);
    chk("postreset_edgecap", bus.readdata, 32'h1);
    chk("postreset_irq", {31'h0, bus.irq}, 32'h0);

    // Falling-edge instance: a press is ignored, the release is captured.
    in_port2[0] = 1'b1;
    repeat (14) @(negedge clk);
    chk("fall_press", bus2.readdata, 32'h0);
    in_port2[0] = 1'b0;
    repeat (14) @(negedge clk);
    chk("fall_release", bus2.readdata, 32'h1);
    chk("fall_irq", {31'h0, bus2.irq}, 32'h0);

    // Randomized run, compared every cycle against the reference model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [1:0]  a;
      logic        cs, wn;
      int          hold;
      hold = (n < 2000) ? 5 : 15;
      for (int b = 0; b < W; b++)
        if ($urandom_range(0, hold) == 0) in_port[b] = ~in_port[b];
      a  = 2'($urandom_range(0, 3));
      cs = 1'($urandom_range(0, 1));
      wn = ($urandom_range(0, 2) != 0);
      cyc(a, cs, wn, $urandom);
      chk("rand_rd", bus.readdata, m_rd);
      chk("rand_irq", {31'h0, bus.irq}, {31'h0, |(m_ecap & m_mask)});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pio_in_debounce.md
# pio_in_debounce

Parametrised Avalon-MM input PIO for board buttons and switches on the HPS lightweight bridge. It is the successor to the fixed 2-bit key port. Each input bit is synchronised and debounced, then presented as a level register. Selected edges are latched in a write-1-to-clear capture register, and a maskable interrupt is raised to the HPS.

## Interface
Parameters:
- WIDTH, 2, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (2..4)
- DEBOUNCE_CYCLES, 50000, cycles a new level must be held before acceptance (>=1; 1 = synchronise only)
- EDGE_TYPE, 2, captured edge: 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt

## Operation
- Register map, bits above WIDTH read 0:
  - 0 DATA (RO): debounced levels.
  - 1 IRQMASK (RW).
  - 2 EDGECAP (RO, write-1-to-clear).
  - 3 reserved; reads 0, writes ignored.
- Write occurs when chipselect=1 and write_n=0. Writes to DATA are ignored.
- Per bit: sync[i] is the last stage of the synchroniser chain. stable[i] is the debounced level. cnt[i] has width clog2(DEBOUNCE_CYCLES)+1.
  - If sync==stable: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: stable<=sync and cnt<=0.
  - Otherwise: cnt<=cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Edge detect compares stable with its value one cycle earlier (stable_d), per EDGE_TYPE. A detected edge sets edgecap[i].
- Set and write-1-clear of the same bit in the same cycle: set wins. Bits cleared by the write stay 0 unless set that cycle.
- irq = |(edgecap & mask). It is combinational from registers and holds until the bit is cleared or masked.
- readdata is updated every cycle from the address mux, independent of chipselect, as in the existing PIOs.

## Timing
- Reset values:
  - Synchroniser flops, stable, stable_d, cnt, edgecap, mask and readdata all 0.
  - irq 0.
- Input latency: an in_port change held steady reaches stable after SYNC_STAGES + DEBOUNCE_CYCLES clock edges.
- Edgecap sets one cycle after stable changes. irq rises in that same cycle when the bit is unmasked.
- Read latency is 1 cycle: readdata reflects the register value at the address-sampling edge.
- A read of EDGECAP in the same cycle as a clear returns the pre-clear value.
- A mask write takes effect on irq the cycle after the write edge.
- Reset asserted mid-debounce: all state returns to 0 immediately. After release, an input held at 1 is re-accepted after the full latency and produces a rising edge.
- cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.

## Structure
- Shared package pio_pkg:
  - Address constants ADDR_DATA=0, ADDR_IRQMASK=1, ADDR_EDGECAP=2.
  - Edge-type encodings EDGE_RISE/EDGE_FALL/EDGE_ANY.
- Sub-module pio_debounce_bit, generated WIDTH times. It contains the synchroniser chain, cnt and stable, and outputs stable only.
- Top level holds stable_d, edgecap, mask, the read mux and irq.

## Test plan
- Reset, then read all four addresses -> readdata 0 each; irq 0.
- DEBOUNCE_CYCLES=8, SYNC_STAGES=2: raise in_port[0] and hold -> DATA bit0=1 exactly 10 edges later; EDGECAP=0x1 one cycle later; irq stays 0 while mask=0.
- Write IRQMASK=0x1 after the edge -> irq=1 the next cycle. Write EDGECAP=0x1 -> irq=0 the cycle after, EDGECAP reads 0.
- Pulse in_port[1] high for 7 cycles with DEBOUNCE_CYCLES=8 -> DATA stays 0, EDGECAP stays 0.
- EDGE_TYPE=1: press then release bit0 -> only the release sets EDGECAP.
- Force a set of bit0 in the same cycle as a write-1-clear of bit0 -> EDGECAP bit0 reads 1. Assert reset mid-count -> all registers read 0.
